ex_stage: RTL
=============

// Module: ex_stage
// PURPOSE
//  Execute stage with the ID/EX pipeline register. Latches id_to_ex_bus, selects operands and runs the 12-op ALU.
//  Issues data-SRAM requests for loads/stores and forwards its result back to ID.
//  Runs DIV/DIVU on a serial 32-iteration divider and stalls the pipeline until the divide completes.
//  Sits between ID and MEM.
// PARAMETERS
//  DIV_ITERS   32   divider iterations (one quotient bit per cycle); fixed for 32-bit operands
// PORTS
//  clk             in   1    clock
//  rst             in   1    reset, synchronous, active-high
//  stall           in   6    pipeline stall vector; bit2 = ID/EX register, bit3 = EX/MEM register
//  id_to_ex_bus    in   159  {pc[158:127],inst[126:95],alu_op[94:83],src1[82:80],src2[79:76],ram_en[75],ram_wen[74:71],rf_we[70],rf_waddr[69:65],sel_rf_res[64],rdata1[63:32],rdata2[31:0]}
//  ex_to_mem_bus   out  76   {pc[75:44],ram_en[43],ram_wen[42:39],sel_rf_res[38],rf_we[37],rf_waddr[36:32],ex_result[31:0]}
//  ex_to_rf_bus    out  38   {we,waddr[4:0],wdata[31:0]} forwarding path to ID
//  data_sram_en    out  1    data SRAM enable
//  data_sram_wen   out  4    byte write enables
//  data_sram_addr  out  32   byte address
//  data_sram_wdata out  32   store data
//  stallreq_for_ex out  1    divider busy; holds stages 0..3
// BEHAVIOUR
//  Pipeline register (posedge clk)
//  - rst: register <= 0.
//  - stall[2]=Stop & stall[3]=NoStop: register <= 0 (bubble).
//  - stall[2]=NoStop: register <= id_to_ex_bus.
//  - Otherwise: hold.
//  Operands
//  - src1: [0] rdata1, [1] pc, [2] {27'b0,inst[10:6]}.
//  - src2: [0] rdata2, [1] sext(inst[15:0]), [2] 32'd8, [3] zext(inst[15:0]).
//  - One-hot select; all-zero selects 0.
//  ALU
//  - alu_op bit11..0 = add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui.
//  - Shifts: src2 is shifted by src1[4:0]. lui = {src2[15:0],16'b0}.
//  - Arithmetic is mod 2^32 with no overflow trap. slt is signed; sltu is unsigned. Result is 0 if no op is set.
//  Memory (decoded from inst[31:26])
//  - Address = rdata1 + sext(inst[15:0]).
//  - Load (lb,lbu,lh,lhu,lw): en=1, wen=0, sel_rf_res forced 1.
//  - sb: wen = 1<<addr[1:0], wdata = {4{rdata2[7:0]}}.
//  - sh: wen = addr[1] ? 1100 : 0011, wdata = {2{rdata2[15:0]}}.
//  - sw: wen = 1111, wdata = rdata2.
//  - Misaligned addresses: low bits ignored, no exception.
//  - en = ram_en_bus | is_mem; wen = ram_wen_bus | derived wen.
//  - Outputs are combinational and qualified by the register contents; a bubble issues no request.
//  HI/LO (internal registers, reset 0)
//  - mfhi/mflo (func 010000/010010): ex_result = hi/lo.
//  - mthi/mtlo (func 010001/010011): hi/lo <= rdata1 on the cycle stall[3]=NoStop.
//  Forwarding
//  - ex_to_rf_bus = {rf_we & ~sel_rf_res, rf_waddr, ex_result}.
//  - Load results are never forwarded from EX.
//  Divider FSM (IDLE, CALC, DONE); reset -> IDLE, stallreq_for_ex=0
//  - IDLE: if inst is div/divu (op 0, func 011010/011011), then:
//    - stallreq_for_ex=1 in the same cycle (combinational);
//    - latch magnitudes (signed) or raw values (unsigned);
//    - cnt<=0 and go to CALC.
//  - CALC: one restoring step per cycle, stallreq_for_ex=1. After cnt=31 go to DONE.
//  - DONE: stallreq_for_ex=0, result held.
//    - Stays in DONE while stall[3]=Stop, so the same instruction is not re-issued.
//    - On stall[3]=NoStop: hi<=remainder, lo<=quotient, go to IDLE.
//  - Latency: stallreq_for_ex is high for 33 cycles (issue cycle plus 32 CALC cycles).
//  - Signed fixup: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
//  - Divide by zero: quotient = 32'hFFFFFFFF, remainder = dividend; same latency.
//  - rst mid-divide: return to IDLE, hi=lo=0, stallreq_for_ex=0 in the next cycle.
//  - A bubble (all-zero inst = sll $0) never starts the divider.
// TESTING
//  - addu src1=rs,src2=rt, rdata1=7, rdata2=FFFFFFFE, rf_waddr=3 -> ex_result=5; ex_to_rf_bus={1,3,5} in the cycle after latch.
//  - sb, rdata1=0x1000, imm=0x0003, rdata2=0xAB -> addr=0x1003, wen=1000, wdata=ABABABAB; ex_to_rf_bus.we=0.
//  - stall[2]=1,stall[3]=0 -> next cycle the register is 0 and data_sram_en=0. stall[2]=1,stall[3]=1 -> register holds.
//  - div -7/2 -> stallreq_for_ex high for exactly 33 cycles; then mflo=FFFFFFFD, mfhi=FFFFFFFF.
//  - divu 10/0 -> lo=FFFFFFFF, hi=10. Hold stall[3]=1 for 3 cycles in DONE -> no re-issue; hi/lo update once.
//  - Assert rst at CALC cnt=15 -> FSM IDLE, stallreq_for_ex=0, hi=lo=0 in the next cycle.

Source files
------------

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage. Holds the ID/EX pipeline register, selects
//                operands, runs the 12-op ALU, issues data-SRAM requests,
//                forwards its result to ID, and performs DIV/DIVU on a serial
//                restoring divider that stalls the pipeline while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int DIV_ITERS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         stallreq_for_ex
);

  localparam int CNT_W = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // --------------------------------------------------------------------------
  // ID/EX pipeline register
  // --------------------------------------------------------------------------
  logic [158:0] id_ex;

  // Latch, bubble or hold the incoming ID bundle depending on the stall vector
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex <= '0;
    end else if (stall[2] && !stall[3]) begin
      id_ex <= '0;
    end else if (!stall[2]) begin
      id_ex <= id_to_ex_bus;
    end
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  src1_sel;
  logic [3:0]  src2_sel;
  logic        ram_en_bus, rf_we, sel_rf_res;
  logic [3:0]  ram_wen_bus;
  logic [4:0]  rf_waddr;

  assign pc          = id_ex[158:127];
  assign inst        = id_ex[126:95];
  assign alu_op      = id_ex[94:83];
  assign src1_sel    = id_ex[82:80];
  assign src2_sel    = id_ex[79:76];
  assign ram_en_bus  = id_ex[75];
  assign ram_wen_bus = id_ex[74:71];
  assign rf_we       = id_ex[70];
  assign rf_waddr    = id_ex[69:65];
  assign sel_rf_res  = id_ex[64];
  assign rdata1      = id_ex[63:32];
  assign rdata2      = id_ex[31:0];

  // --------------------------------------------------------------------------
  // Instruction decode for memory, HI/LO and divide
  // --------------------------------------------------------------------------
  logic [5:0]  opcode, func;
  logic [31:0] imm_sext, imm_zext;
  logic        is_rtype, is_load, is_sb, is_sh, is_sw, is_mem;
  logic        is_mfhi, is_mflo, is_mthi, is_mtlo, is_div, is_div_signed;

  assign opcode   = inst[31:26];
  assign func     = inst[5:0];
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'b0, inst[15:0]};

  assign is_rtype = (opcode == 6'b000000);
  assign is_load  = (opcode == 6'b100000) || (opcode == 6'b100100) ||
                    (opcode == 6'b100001) || (opcode == 6'b100101) ||
                    (opcode == 6'b100011);
  assign is_sb    = (opcode == 6'b101000);
  assign is_sh    = (opcode == 6'b101001);
  assign is_sw    = (opcode == 6'b101011);
  assign is_mem   = is_load || is_sb || is_sh || is_sw;

  assign is_mfhi       = is_rtype && (func == 6'b010000);
  assign is_mthi       = is_rtype && (func == 6'b010001);
  assign is_mflo       = is_rtype && (func == 6'b010010);
  assign is_mtlo       = is_rtype && (func == 6'b010011);
  assign is_div        = is_rtype && ((func == 6'b011010) || (func == 6'b011011));
  assign is_div_signed = !func[0];

  // --------------------------------------------------------------------------
  // Operand select and ALU (one-hot selects and op vector, OR-combined)
  // --------------------------------------------------------------------------
  logic [31:0] src_a, src_b, alu_res;
  logic [4:0]  shamt;

  assign src_a = ({32{src1_sel[0]}} & rdata1) |
                 ({32{src1_sel[1]}} & pc) |
                 ({32{src1_sel[2]}} & {27'b0, inst[10:6]});

  assign src_b = ({32{src2_sel[0]}} & rdata2) |
                 ({32{src2_sel[1]}} & imm_sext) |
                 ({32{src2_sel[2]}} & 32'd8) |
                 ({32{src2_sel[3]}} & imm_zext);

  assign shamt = src_a[4:0];

  // Merge every enabled ALU function into one result word
  always_comb begin
    alu_res = 32'b0;
    if (alu_op[11]) alu_res = alu_res | (src_a + src_b);
    if (alu_op[10]) alu_res = alu_res | (src_a - src_b);
    if (alu_op[9])  alu_res = alu_res | {31'b0, ($signed(src_a) < $signed(src_b))};
    if (alu_op[8])  alu_res = alu_res | {31'b0, (src_a < src_b)};
    if (alu_op[7])  alu_res = alu_res | (src_a & src_b);
    if (alu_op[6])  alu_res = alu_res | ~(src_a | src_b);
    if (alu_op[5])  alu_res = alu_res | (src_a | src_b);
    if (alu_op[4])  alu_res = alu_res | (src_a ^ src_b);
    if (alu_op[3])  alu_res = alu_res | (src_b << shamt);
    if (alu_op[2])  alu_res = alu_res | (src_b >> shamt);
    if (alu_op[1])  alu_res = alu_res | 32'($signed(src_b) >>> shamt);
    if (alu_op[0])  alu_res = alu_res | {src_b[15:0], 16'b0};
  end

  // --------------------------------------------------------------------------
  // Data SRAM request
  // --------------------------------------------------------------------------
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wen;

  assign mem_addr = rdata1 + imm_sext;

  // Derive byte enables and replicated store data from the store width
  always_comb begin
    mem_wen   = 4'b0000;
    mem_wdata = rdata2;
    if (is_sb) begin
      mem_wen   = 4'b0001 << mem_addr[1:0];
      mem_wdata = {4{rdata2[7:0]}};
    end else if (is_sh) begin
      mem_wen   = mem_addr[1] ? 4'b1100 : 4'b0011;
      mem_wdata = {2{rdata2[15:0]}};
    end else if (is_sw) begin
      mem_wen   = 4'b1111;
    end
  end

  assign data_sram_en    = ram_en_bus | is_mem;
  assign data_sram_wen   = ram_wen_bus | mem_wen;
  assign data_sram_addr  = mem_addr;
  assign data_sram_wdata = mem_wdata;

  // --------------------------------------------------------------------------
  // Divider FSM and datapath
  // --------------------------------------------------------------------------
  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rem, quo, dsor;
  logic             neg_q, neg_r, div_zero;
  logic [32:0]      step_shift;
  logic [31:0]      step_diff;
  logic             step_ge;
  logic [31:0]      abs1, abs2, quo_fix, rem_fix;

  assign abs1 = rdata1[31] ? (~rdata1 + 32'd1) : rdata1;
  assign abs2 = rdata2[31] ? (~rdata2 + 32'd1) : rdata2;

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  // The partial remainder always fits in 32 bits after a successful subtract.
  assign step_shift = {rem, quo[31]};
  assign step_ge    = (step_shift >= {1'b0, dsor});
  assign step_diff  = step_shift[31:0] - dsor;

  assign quo_fix = div_zero ? 32'hFFFF_FFFF : (neg_q ? (~quo + 32'd1) : quo);
  assign rem_fix = neg_r ? (~rem + 32'd1) : rem;

  // Divider state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Divider next-state and stall request
  always_comb begin
    state_nxt       = state;
    stallreq_for_ex = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_div) begin
          stallreq_for_ex = 1'b1;
          state_nxt       = S_CALC;
        end
      end
      S_CALC: begin
        stallreq_for_ex = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!stall[3]) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Divider operand capture and iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= 32'b0;
      quo      <= 32'b0;
      dsor     <= 32'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (state == S_IDLE && is_div) begin
      cnt      <= '0;
      rem      <= 32'b0;
      quo      <= is_div_signed ? abs1 : rdata1;
      dsor     <= is_div_signed ? abs2 : rdata2;
      neg_q    <= is_div_signed && (rdata1[31] ^ rdata2[31]);
      neg_r    <= is_div_signed && rdata1[31];
      div_zero <= (rdata2 == 32'b0);
    end else if (state == S_CALC) begin
      cnt <= cnt + 1'b1;
      rem <= step_ge ? step_diff : step_shift[31:0];
      quo <= {quo[30:0], step_ge};
    end
  end

  // --------------------------------------------------------------------------
  // HI/LO registers
  // --------------------------------------------------------------------------
  logic [31:0] hi, lo;

  // Commit divide results or mthi/mtlo writes when EX/MEM advances
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 32'b0;
      lo <= 32'b0;
    end else if (!stall[3]) begin
      if (state == S_DONE) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        if (is_mthi) hi <= rdata1;
        if (is_mtlo) lo <= rdata1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result and output buses
  // --------------------------------------------------------------------------
  logic [31:0] ex_result;
  logic        sel_rf_res_eff;

  assign ex_result      = is_mfhi ? hi : (is_mflo ? lo : alu_res);
  assign sel_rf_res_eff = sel_rf_res | is_load;

  assign ex_to_mem_bus = {pc, data_sram_en, data_sram_wen, sel_rf_res_eff,
                          rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus  = {rf_we & ~sel_rf_res_eff, rf_waddr, ex_result};

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0]};

endmodule
`default_nettype wire
